// File: rtl/bldc_if.sv
// Host-side command and gate-pin bundle for bldc_driver.
// The host drives the command fields, and the driver drives the gate and enable pins.
interface bldc_if;
    logic signed [15:0] velocity;
    logic signed [7:0]  offset;
    logic               enable;
    logic [7:0]         mode;
    logic signed [11:0] feedback;
    logic               u_p, v_p, w_p;
    logic               u_n, v_n, w_n;
    logic               en;

    modport master (
        output velocity, offset, enable, mode, feedback,
        input  u_p, v_p, w_p, u_n, v_n, w_n, en
    );

    modport slave (
        input  velocity, offset, enable, mode, feedback,
        output u_p, v_p, w_p, u_n, v_n, w_n, en
    );
endinterface

// File: rtl/bldc_driver.sv
// Three-phase sinusoidal BLDC commutation driver with centre-referenced PWM.
// Optional feature macro: BLDC_DEADTIME_EN inserts a 4-clock gate dead time when PWMMODE is 0.
module bldc_driver #(
    parameter int PWMMODE          = 0,
    parameter int FEEDBACK_DIVIDER = 16,
    parameter int DIVIDER          = 0
) (
    input logic   clk,
    input logic   rst_n,
    bldc_if.slave bus
);

    localparam int FB_SHIFT = $clog2(FEEDBACK_DIVIDER);

    // Quarter-wave of round(127*sin(2*pi*k/256)) for k = 0..64.
    function automatic logic [6:0] quarter(input logic [6:0] i);
        case (i)
            7'd0:  return 7'd0;   7'd1:  return 7'd3;   7'd2:  return 7'd6;   7'd3:  return 7'd9;
            7'd4:  return 7'd12;  7'd5:  return 7'd16;  7'd6:  return 7'd19;  7'd7:  return 7'd22;
            7'd8:  return 7'd25;  7'd9:  return 7'd28;  7'd10: return 7'd31;  7'd11: return 7'd34;
            7'd12: return 7'd37;  7'd13: return 7'd40;  7'd14: return 7'd43;  7'd15: return 7'd46;
            7'd16: return 7'd49;  7'd17: return 7'd51;  7'd18: return 7'd54;  7'd19: return 7'd57;
            7'd20: return 7'd60;  7'd21: return 7'd63;  7'd22: return 7'd65;  7'd23: return 7'd68;
            7'd24: return 7'd71;  7'd25: return 7'd73;  7'd26: return 7'd76;  7'd27: return 7'd78;
            7'd28: return 7'd81;  7'd29: return 7'd83;  7'd30: return 7'd85;  7'd31: return 7'd88;
            7'd32: return 7'd90;  7'd33: return 7'd92;  7'd34: return 7'd94;  7'd35: return 7'd96;
            7'd36: return 7'd98;  7'd37: return 7'd100; 7'd38: return 7'd102; 7'd39: return 7'd104;
            7'd40: return 7'd106; 7'd41: return 7'd107; 7'd42: return 7'd109; 7'd43: return 7'd111;
            7'd44: return 7'd112; 7'd45: return 7'd113; 7'd46: return 7'd115; 7'd47: return 7'd116;
            7'd48: return 7'd117; 7'd49: return 7'd118; 7'd50: return 7'd120; 7'd51: return 7'd121;
            7'd52: return 7'd122; 7'd53: return 7'd122; 7'd54: return 7'd123; 7'd55: return 7'd124;
            7'd56: return 7'd125; 7'd57: return 7'd125; 7'd58: return 7'd126; 7'd59: return 7'd126;
            7'd60: return 7'd126; 7'd61: return 7'd127; 7'd62: return 7'd127; 7'd63: return 7'd127;
            7'd64: return 7'd127;
            default: return 7'd0;
        endcase
    endfunction

    // Full-wave sine, returned as two's complement.
    function automatic logic [7:0] sine(input logic [7:0] k);
        logic [6:0] idx;
        logic [6:0] mag;
        idx = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
        mag = quarter(idx);
        return k[7] ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
    endfunction

    function automatic logic [7:0] duty_of(input logic [7:0] s, input logic [7:0] a);
        logic signed [17:0] prod;
        logic signed [17:0] d;
        prod = $signed({{10{s[7]}}, s}) * $signed({10'd0, a});
        d    = 18'sd128 + (prod >>> 8);
        if (d < 18'sd0)        return 8'd0;
        else if (d > 18'sd255) return 8'd255;
        else                   return d[7:0];
    endfunction

    logic [15:0]      presc_q, presc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [15:0]      acc_q, acc_d;
    logic [2:0][7:0]  th_q, th_d;
    logic [7:0]       amp1_q, amp1_d, amp2_q, amp2_d;
    logic [2:0][7:0]  s_q, s_d;
    logic [2:0][7:0]  duty_nx_q, duty_nx_d;
    logic [2:0][7:0]  duty_act_q, duty_act_d;
    logic [2:0]       gp_q, gp_d, gn_q, gn_d;
    logic             en_q, en_d;

    logic             tick, wrap;
    logic [7:0]       fb_angle, base, lead, theta;
    logic [15:0]      mag;
    logic [2:0]       want_p, want_n;

`ifdef BLDC_DEADTIME_EN
    logic [2:0][1:0]  offp_q, offp_d, offn_q, offn_d;
`endif

    always_comb begin
        tick    = (presc_q == 16'(DIVIDER));
        wrap    = tick && (cnt_q == 8'hFF);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
        acc_d   = wrap ? acc_q + $unsigned(bus.velocity) : acc_q;

        fb_angle = 8'($unsigned(bus.feedback) >> FB_SHIFT);
        base     = (bus.mode == 8'd1) ? acc_q[15:8] : fb_angle;
        lead     = bus.velocity[15] ? 8'd192 : 8'd64;
        theta    = base + $unsigned(bus.offset) + lead;
        th_d[0]  = theta;
        th_d[1]  = theta + 8'd85;
        th_d[2]  = theta + 8'd171;

        // -32768 negates to 0x8000, which saturates exactly as 32767 would.
        mag    = bus.velocity[15] ? (16'd0 - $unsigned(bus.velocity)) : $unsigned(bus.velocity);
        amp1_d = (mag > 16'd255) ? 8'd255 : mag[7:0];
        amp2_d = amp1_q;
        en_d   = bus.enable;

        s_d        = '0;
        duty_nx_d  = '0;
        duty_act_d = '0;
        want_p     = '0;
        want_n     = '0;
        gp_d       = '0;
        gn_d       = '0;
`ifdef BLDC_DEADTIME_EN
        offp_d     = '0;
        offn_d     = '0;
`endif
        for (int i = 0; i < 3; i++) begin
            s_d[i]        = sine(th_q[i]);
            duty_nx_d[i]  = duty_of(s_q[i], amp2_q);
            duty_act_d[i] = wrap ? duty_nx_q[i] : duty_act_q[i];
            want_p[i]     = bus.enable && (cnt_q < duty_act_q[i]);
            want_n[i]     = bus.enable && !(cnt_q < duty_act_q[i]) && (PWMMODE == 0);
`ifdef BLDC_DEADTIME_EN
            offp_d[i] = gp_q[i] ? 2'd0 : ((offp_q[i] == 2'd3) ? 2'd3 : offp_q[i] + 2'd1);
            offn_d[i] = gn_q[i] ? 2'd0 : ((offn_q[i] == 2'd3) ? 2'd3 : offn_q[i] + 2'd1);
            // Turn-on needs the opposite gate low now and for the 3 clocks before.
            if (PWMMODE == 0) begin
                gp_d[i] = want_p[i] && !gn_q[i] && (offn_q[i] == 2'd3);
                gn_d[i] = want_n[i] && !gp_q[i] && (offp_q[i] == 2'd3);
            end else begin
                gp_d[i] = want_p[i];
                gn_d[i] = 1'b0;
            end
`else
            gp_d[i] = want_p[i];
            gn_d[i] = want_n[i];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            th_q       <= '0;
            amp1_q     <= '0;
            amp2_q     <= '0;
            s_q        <= '0;
            duty_nx_q  <= {3{8'd128}};
            duty_act_q <= {3{8'd128}};
            gp_q       <= '0;
            gn_q       <= '0;
            en_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            th_q       <= th_d;
            amp1_q     <= amp1_d;
            amp2_q     <= amp2_d;
            s_q        <= s_d;
            duty_nx_q  <= duty_nx_d;
            duty_act_q <= duty_act_d;
            gp_q       <= gp_d;
            gn_q       <= gn_d;
            en_q       <= en_d;
        end
    end

`ifdef BLDC_DEADTIME_EN
    // Both gates are off in reset, so the off-time counters start saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offp_q <= {3{2'd3}};
            offn_q <= {3{2'd3}};
        end else begin
            offp_q <= offp_d;
            offn_q <= offn_d;
        end
    end
`endif

    assign bus.u_p = gp_q[0];
    assign bus.v_p = gp_q[1];
    assign bus.w_p = gp_q[2];
    assign bus.u_n = gn_q[0];
    assign bus.v_n = gn_q[1];
    assign bus.w_n = gn_q[2];
    assign bus.en  = en_q;

endmodule

// File: tb/tb_bldc_driver.sv
// Scoreboard bench for bldc_driver: expected per-period high-side on-times are queued at stimulus
// and compared against on-times counted over a steady 256-clock window.
module tb_bldc_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bldc_if bif();

    bldc_driver #(
        .PWMMODE(0),
        .FEEDBACK_DIVIDER(16),
        .DIVIDER(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bif)
    );

    typedef struct {
        string tag;
        int    du;
        int    dv;
        int    dw;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sin_ref(input int k);
        real r;
        r = 127.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
        if (r >= 0.0) return $rtoi($floor(r + 0.5));
        else          return -$rtoi($floor(-r + 0.5));
    endfunction

    function automatic int duty_ref(input int s, input int a);
        int p;
        int d;
        p = s * a;
        d = 128 + (p >>> 8);
        if (d < 0)   d = 0;
        if (d > 255) d = 255;
        return d;
    endfunction

    // Expected high-side on-time per period for a duty in steady state.
    function automatic int on_time(input int d);
`ifdef BLDC_DEADTIME_EN
        return (d > 4) ? d - 4 : 0;
`else
        return d;
`endif
    endfunction

    // Open-loop cases run just after reset with |velocity| tiny, so acc[15:8] is still 0.
    task automatic apply(input string tag, input int vel, input int off, input int md, input int fb);
        int   mag, a, base, th;
        exp_t e;
        bif.velocity = 16'(vel);
        bif.offset   = 8'(off);
        bif.mode     = 8'(md);
        bif.feedback = 12'(fb);
        mag  = (vel < 0) ? -vel : vel;
        a    = (mag > 255) ? 255 : mag;
        base = (md == 1) ? 0 : ((fb >> 4) & 255);
        th   = (base + off + ((vel >= 0) ? 64 : -64)) & 255;
        e.tag = tag;
        e.du  = on_time(duty_ref(sin_ref(th), a));
        e.dv  = on_time(duty_ref(sin_ref((th + 85) & 255), a));
        e.dw  = on_time(duty_ref(sin_ref((th + 171) & 255), a));
        sb_q.push_back(e);
    endtask

    task automatic run_window(output int hu, output int hv, output int hw, output int bad);
        hu = 0; hv = 0; hw = 0; bad = 0;
        repeat (256) begin
            @(posedge clk); #1;
            hu += int'(bif.u_p);
            hv += int'(bif.v_p);
            hw += int'(bif.w_p);
`ifdef BLDC_DEADTIME_EN
            bad += int'(bif.u_p && bif.u_n) + int'(bif.v_p && bif.v_n) + int'(bif.w_p && bif.w_n);
`else
            bad += int'(bif.u_n == bif.u_p) + int'(bif.v_n == bif.v_p) + int'(bif.w_n == bif.w_p);
`endif
        end
    endtask

    task automatic check_window();
        exp_t e;
        int   hu, hv, hw, bad;
        if (sb_q.size() == 0) begin
            chk("scoreboard underrun", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        run_window(hu, hv, hw, bad);
        chk({e.tag, " u_p on-time"}, hu, e.du);
        chk({e.tag, " v_p on-time"}, hv, e.dv);
        chk({e.tag, " w_p on-time"}, hw, e.dw);
        chk({e.tag, " gate pairing"}, bad, 0);
        chk({e.tag, " en"}, int'(bif.en), 1);
    endtask

    task automatic settle();
        repeat (512) @(posedge clk);
        #1;
    endtask

    task automatic find_rise(output int at, output int found);
        logic prev;
        found = 0;
        at = 0;
        prev = bif.u_p;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (bif.u_p && !prev) begin
                at = cyc;
                found = 1;
                break;
            end
            prev = bif.u_p;
        end
    endtask

    function automatic int gate_sum();
        return int'(bif.u_p) + int'(bif.v_p) + int'(bif.w_p)
             + int'(bif.u_n) + int'(bif.v_n) + int'(bif.w_n);
    endfunction

    initial begin
        exp_t e;
        int   r0, r1, f0, f1;

        bif.velocity = 16'sd100;
        bif.offset   = 8'sd0;
        bif.enable   = 1'b1;
        bif.mode     = 8'd0;
        bif.feedback = 12'sd0;

        repeat (5) @(posedge clk);
        #1;
        chk("reset gates", gate_sum(), 0);
        chk("reset en", int'(bif.en), 0);

        // Release: first period must still run on the reset duties of 128.
        e.tag = "post-reset";
        e.du = 128; e.dv = 128; e.dw = 128;
        sb_q.push_back(e);
        rst_n = 1'b1;
        check_window();

        apply("v=100", 100, 0, 0, 0);                 settle(); check_window();
        apply("v=0", 0, 0, 0, 0);                     settle(); check_window();
        apply("v=-100", -100, 0, 0, 0);               settle(); check_window();
        apply("v=-100 fb+16", -100, 0, 0, 16);        settle(); check_window();
        apply("v=300 trim", 300, -20, 0, 12'h123);    settle(); check_window();
        apply("v=-32768", -32768, 37, 0, 12'hABC);    settle(); check_window();
        apply("mode2 as closed", 20000, 5, 2, 12'h7F0); settle(); check_window();

        apply("v=100 again", 100, 0, 0, 0);           settle(); check_window();
        find_rise(r0, f0);
        chk("rise before disable", f0, 1);
        repeat (100) @(posedge clk);
        #1;
        bif.enable = 1'b0;
        @(posedge clk); #1;
        chk("disable en", int'(bif.en), 0);
        chk("disable gates", gate_sum(), 0);
        repeat (50) @(posedge clk);
        #1;
        chk("disabled gates hold", gate_sum(), 0);
        bif.enable = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        find_rise(r1, f1);
        chk("rise after enable", f1, 1);
        chk("period phase kept", (r1 - r0) % 256, 0);

        // Reset mid-period clears gates without waiting for a clock edge.
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async reset gates", gate_sum(), 0);
        repeat (3) @(posedge clk);
        #1;
        apply("open loop v=1", 1, 0, 1, 12'h800);
        rst_n = 1'b1;
        settle(); check_window();
        apply("closed loop v=1", 1, 0, 2, 12'h800);   settle(); check_window();

        chk("scoreboard drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
